// File: rtl/starfield_parallax_gen.sv
// VGA-style timing generator drawing a scrolling multi-layer LFSR starfield.
// Every output is registered one cycle after the counter state it reflects.
module starfield_parallax_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int LAYERS       = 3,
  parameter int COLOR_W      = 2,
  parameter int DENSITY_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic               twinkle_en,
  input  logic               invert,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic               de,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] seed_init(input int k);
    case (k)
      0:       return 16'hACE1;
      1:       return 16'h5A3C;
      2:       return 16'hC0DE;
      default: return 16'h1234;
    endcase
  endfunction

  // Brighter for nearer (higher-index) layers, never fully dark.
  function automatic logic [COLOR_W-1:0] layer_level(input int k);
    int v;
    v = ((k + 1) * ((1 << COLOR_W) - 1)) / LAYERS;
    if (v < 1) v = 1;
    return COLOR_W'(v);
  endfunction

  logic [HW-1:0]    hcount;
  logic [VW-1:0]    vcount;
  logic [15:0]      frame_seed [LAYERS];
  logic [15:0]      row        [LAYERS];
  logic [15:0]      pix        [LAYERS];
  logic [15:0]      row_next   [LAYERS];
  logic [7:0]       twinkle;
  logic             scroll_en;
  logic             active, line_end, frame_end, scroll_go, dim;
  logic             hsync_raw, vsync_raw;
  logic [COLOR_W-1:0] r_pix, g_pix, b_pix;

  // scroll_en carries the pause decision from hcount 0 through the rest of the burst.
  always_comb begin
    active    = (hcount < H_ACT) && (vcount < V_ACT);
    line_end  = (hcount == H_LAST);
    frame_end = (vcount == V_LAST);
    hsync_raw = (hcount >= HS_BEG) && (hcount < HS_END);
    vsync_raw = (vcount >= VS_BEG) && (vcount < VS_END);
    scroll_go = (vcount == V_ACT) && ((hcount == '0) ? !pause : scroll_en);
    dim       = twinkle_en && !twinkle[vcount[2:0]];
    r_pix = '0;
    g_pix = '0;
    b_pix = '0;
    for (int k = 0; k < LAYERS; k++) begin
      row_next[k] = frame_end ? frame_seed[k] : lfsr_step(row[k]);
      if (active && (&pix[k][DENSITY_BITS-1:0])) begin
        b_pix = layer_level(k);
        r_pix = dim ? (layer_level(k) >> 1) : layer_level(k);
        g_pix = r_pix;
      end
    end
    if (active && invert) begin
      r_pix = ~r_pix;
      g_pix = ~g_pix;
      b_pix = ~b_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      twinkle     <= 8'hA5;
      scroll_en   <= 1'b0;
      for (int k = 0; k < LAYERS; k++) begin
        frame_seed[k] <= seed_init(k);
        row[k]        <= seed_init(k);
        pix[k]        <= seed_init(k);
      end
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      if (line_end) begin
        hcount  <= '0;
        vcount  <= frame_end ? '0 : vcount + 1'b1;
        twinkle <= {twinkle[6:0], twinkle[7] ^ twinkle[5] ^ twinkle[4] ^ twinkle[3]};
      end else begin
        hcount <= hcount + 1'b1;
      end
      if (hcount == '0 && vcount == V_ACT)
        scroll_en <= !pause;
      for (int k = 0; k < LAYERS; k++) begin
        if (line_end) begin
          row[k] <= row_next[k];
          pix[k] <= row_next[k];
        end else if (active) begin
          pix[k] <= lfsr_step(pix[k]);
        end
        if (scroll_go && hcount <= HW'(k))
          frame_seed[k] <= lfsr_step(frame_seed[k]);
      end
      hsync_n     <= !hsync_raw;
      vsync_n     <= !vsync_raw;
      de          <= active;
      frame_start <= (hcount == '0) && (vcount == '0);
      red         <= r_pix;
      green       <= g_pix;
      blue        <= b_pix;
    end
  end

endmodule
